// File: rtl/nios_dbg_ocimem_arbiter.sv
// rtl/nios_dbg_ocimem_arbiter.sv - OCI RAM single-port arbiter between JTAG debug command path and CPU debug slave
module nios_dbg_ocimem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    // JTAG debug slave command path (system clock domain)
    input  logic              jtag_req,
    input  logic              jtag_wr,
    input  logic [ADDR_W-1:0] jtag_addr,
    input  logic [DATA_W-1:0] jtag_wdata,
    input  logic              debugack,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    // CPU-side Avalon-MM debug slave
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_writedata,
    output logic [DATA_W-1:0] cpu_readdata,
    output logic              cpu_waitrequest,
    // OCI RAM port
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    // Latched JTAG command; r_j_pend stays high until that command completes
    logic                r_j_pend;
    logic                r_j_wr;
    logic [ADDR_W-1:0]   r_j_addr;
    logic [DATA_W-1:0]   r_j_wdata;

    // CPU command seen at a previous edge and not yet completed; gives the
    // CPU the same one-edge request latency as the JTAG capture register
    logic                r_c_pend;

    // Grant bookkeeping: source of the access in flight, its direction, and
    // the round-robin pointer (1 = JTAG was granted last)
    logic                r_grant_jtag;
    logic                r_op_wr;
    logic                r_last_jtag;

    logic [DATA_W-1:0]   r_mon_dreg;
    logic                r_mon_ready;
    logic                r_mon_error;

    logic                w_cpu_cmd;
    logic                w_j_accept;
    logic                w_j_overflow;
    logic                w_grant_valid;
    logic                w_grant_jtag;

    logic [ADDR_W-1:0]   w_ram_addr;
    logic [DATA_W-1:0]   w_ram_wdata;
    logic                w_ram_we;
    logic                w_ram_re;
    logic [DATA_W-1:0]   w_cpu_rdata;
    logic                w_cpu_done;
    logic                w_j_done;
    logic                w_j_capture;
    logic                w_j_wr_blocked;

    assign w_cpu_cmd    = cpu_read | cpu_write;
    // A new strobe is only taken while nothing from JTAG is queued or in flight
    assign w_j_accept   = jtag_req & ~r_j_pend;
    assign w_j_overflow = jtag_req &  r_j_pend;

    // Round-robin: on a tie the side that did not win last time goes first
    assign w_grant_valid = (r_state == ST_IDLE) & (r_j_pend | r_c_pend);
    assign w_grant_jtag  = r_j_pend & (~r_c_pend | ~r_last_jtag);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state: writes finish in ACCESS, reads take one CAPTURE cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_next_state = r_op_wr ? ST_IDLE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: RAM drive, completion strobes and CPU read-data routing
    always_comb begin
        w_ram_addr     = '0;
        w_ram_wdata    = '0;
        w_ram_we       = 1'b0;
        w_ram_re       = 1'b0;
        w_cpu_rdata    = '0;
        w_cpu_done     = 1'b0;
        w_j_done       = 1'b0;
        w_j_capture    = 1'b0;
        w_j_wr_blocked = 1'b0;
        case (r_state)
            ST_ACCESS: begin
                w_ram_addr  = r_grant_jtag ? r_j_addr  : cpu_address;
                w_ram_wdata = r_grant_jtag ? r_j_wdata : cpu_writedata;
                if (r_op_wr) begin
                    // JTAG may only modify debug memory while the CPU is halted
                    w_j_wr_blocked = r_grant_jtag & ~debugack;
                    w_ram_we       = ~w_j_wr_blocked;
                    w_j_done       = r_grant_jtag;
                    w_cpu_done     = ~r_grant_jtag;
                end else begin
                    w_ram_re = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (r_grant_jtag) begin
                    w_j_done    = 1'b1;
                    w_j_capture = 1'b1;
                end else begin
                    w_cpu_done  = 1'b1;
                    w_cpu_rdata = ram_rdata;
                end
            end
            default: begin
            end
        endcase
    end

    // JTAG command capture; pending until its completion cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_j_pend  <= 1'b0;
            r_j_wr    <= 1'b0;
            r_j_addr  <= '0;
            r_j_wdata <= '0;
        end else if (w_j_accept) begin
            r_j_pend  <= 1'b1;
            r_j_wr    <= jtag_wr;
            r_j_addr  <= jtag_addr;
            r_j_wdata <= jtag_wdata;
        end else if (w_j_done) begin
            r_j_pend  <= 1'b0;
        end
    end

    // CPU request tracking; cleared on the edge closing its completion cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_c_pend <= 1'b0;
        end else if (w_cpu_done) begin
            r_c_pend <= 1'b0;
        end else begin
            r_c_pend <= w_cpu_cmd;
        end
    end

    // Grant registers; read+write together from the CPU counts as a write
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant_jtag <= 1'b0;
            r_op_wr      <= 1'b0;
            r_last_jtag  <= 1'b0;
        end else if (w_grant_valid) begin
            r_grant_jtag <= w_grant_jtag;
            r_op_wr      <= w_grant_jtag ? r_j_wr : cpu_write;
            r_last_jtag  <= w_grant_jtag;
        end
    end

    // JTAG monitor status and read-data register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mon_dreg  <= '0;
            r_mon_ready <= 1'b0;
            r_mon_error <= 1'b0;
        end else begin
            if (w_j_accept) begin
                r_mon_ready <= 1'b0;
            end else if (w_j_done) begin
                r_mon_ready <= 1'b1;
            end
            if (w_j_accept) begin
                r_mon_error <= 1'b0;
            end else if (w_j_overflow | w_j_wr_blocked) begin
                r_mon_error <= 1'b1;
            end
            if (w_j_capture) begin
                r_mon_dreg <= ram_rdata;
            end
        end
    end

    assign MonDReg         = r_mon_dreg;
    assign monitor_ready   = r_mon_ready;
    assign monitor_error   = r_mon_error;
    assign cpu_readdata    = w_cpu_rdata;
    assign cpu_waitrequest = w_cpu_cmd & ~w_cpu_done;
    assign ram_addr        = w_ram_addr;
    assign ram_wdata       = w_ram_wdata;
    assign ram_we          = w_ram_we;
    assign ram_re          = w_ram_re;

endmodule

// File: tb/tb_nios_dbg_ocimem_arbiter.sv
// tb/tb_nios_dbg_ocimem_arbiter.sv - directed scoreboard bench for nios_dbg_ocimem_arbiter
module tb_nios_dbg_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        jtag_req, jtag_wr, debugack;
    logic [7:0]  jtag_addr;
    logic [31:0] jtag_wdata;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;
    logic        cpu_read, cpu_write;
    logic [7:0]  cpu_address;
    logic [31:0] cpu_writedata, cpu_readdata;
    logic        cpu_waitrequest;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        ram_we, ram_re;

    logic        tb_load;
    logic [7:0]  tb_load_addr;
    logic [31:0] tb_load_data;
    logic [31:0] mem [0:255];

    logic [31:0] exp_q [$];
    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;
    int          lat;

    always #5 clk = ~clk;

    nios_dbg_ocimem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .jtag_req       (jtag_req),
        .jtag_wr        (jtag_wr),
        .jtag_addr      (jtag_addr),
        .jtag_wdata     (jtag_wdata),
        .debugack       (debugack),
        .MonDReg        (MonDReg),
        .monitor_ready  (monitor_ready),
        .monitor_error  (monitor_error),
        .cpu_read       (cpu_read),
        .cpu_write      (cpu_write),
        .cpu_address    (cpu_address),
        .cpu_writedata  (cpu_writedata),
        .cpu_readdata   (cpu_readdata),
        .cpu_waitrequest(cpu_waitrequest),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_we         (ram_we),
        .ram_re         (ram_re),
        .ram_rdata      (ram_rdata)
    );

    // OCI RAM model: synchronous write, read data one cycle after ram_re
    always @(posedge clk) begin
        if (tb_load) mem[tb_load_addr] <= tb_load_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        else chk(tag, obs, exp_q.pop_front());
    endtask

    task automatic jtag_cmd(input logic wr, input logic [7:0] a, input logic [31:0] d);
        jtag_req = 1'b1; jtag_wr = wr; jtag_addr = a; jtag_wdata = d;
        step();
        jtag_req = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!monitor_ready && n < 20) begin
            step();
            n++;
        end
        chk("jtag_ready_timeout", {31'd0, monitor_ready}, 32'd1);
    endtask

    // Issues one CPU command; lat is the cycle index of the waitrequest-low cycle
    task automatic cpu_op(input logic wr, input logic [7:0] a, input logic [31:0] d, output int l);
        cpu_write = wr; cpu_read = ~wr; cpu_address = a; cpu_writedata = d;
        l = -1;
        do begin
            step();
            l++;
        end while (cpu_waitrequest && l < 20);
        chk("cpu_timeout", {31'd0, cpu_waitrequest}, 32'd0);
        if (!wr) sb_pop("cpu_rdata", cpu_readdata);
        step();
        cpu_write = 1'b0; cpu_read = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; jtag_req = 0; jtag_wr = 0; jtag_addr = 0; jtag_wdata = 0; debugack = 1'b1;
        cpu_read = 0; cpu_write = 0; cpu_address = 0; cpu_writedata = 0;
        tb_load = 0; tb_load_addr = 0; tb_load_data = 0;
        step(); step();

        // Reset state
        cpu_read = 1'b1; #1;
        chk("rst_waitreq", {31'd0, cpu_waitrequest}, 32'd1);
        cpu_read = 1'b0;
        chk("rst_mondreg", MonDReg, 32'd0);
        chk("rst_ready", {31'd0, monitor_ready}, 32'd0);
        chk("rst_error", {31'd0, monitor_error}, 32'd0);
        chk("rst_we_re", {30'd0, ram_we, ram_re}, 32'd0);

        tb_load = 1'b1; tb_load_addr = 8'h10; tb_load_data = 32'hDEADBEEF;
        step();
        tb_load = 1'b0;
        reset = 1'b0;
        step();

        // Uncontended JTAG read
        exp_q.push_back(32'hDEADBEEF);
        jtag_cmd(1'b0, 8'h10, 32'h0);
        chk("jrd_c0_re", {31'd0, ram_re}, 32'd0);
        step();
        chk("jrd_c1_re", {31'd0, ram_re}, 32'd1);
        chk("jrd_c1_addr", {24'd0, ram_addr}, 32'h10);
        step();
        chk("jrd_c2_ready", {31'd0, monitor_ready}, 32'd0);
        step();
        chk("jrd_c3_ready", {31'd0, monitor_ready}, 32'd1);
        sb_pop("jrd_mondreg", MonDReg);
        chk("jrd_error", {31'd0, monitor_error}, 32'd0);

        // CPU write then read back
        cpu_op(1'b1, 8'h05, 32'h12345678, lat);
        chk("cwr_lat", lat, 32'd1);
        chk("cwr_mem", mem[8'h05], 32'h12345678);
        exp_q.push_back(32'h12345678);
        cpu_op(1'b0, 8'h05, 32'h0, lat);
        chk("crd_lat", lat, 32'd2);

        // Contention after reset pointer: JTAG first, CPU right after the IDLE gap
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h12345678);
        cpu_read = 1'b1; cpu_address = 8'h05;
        jtag_cmd(1'b0, 8'h10, 32'h0);
        chk("p1_c0_re", {31'd0, ram_re}, 32'd0);
        step();
        chk("p1_c1_addr", {23'd0, ram_re, ram_addr}, 32'h110);
        chk("p1_c1_wreq", {31'd0, cpu_waitrequest}, 32'd1);
        step();
        chk("p1_c2_wreq", {31'd0, cpu_waitrequest}, 32'd1);
        step();
        chk("p1_c3_re", {31'd0, ram_re}, 32'd0);
        chk("p1_c3_ready", {31'd0, monitor_ready}, 32'd1);
        sb_pop("p1_mondreg", MonDReg);
        step();
        chk("p1_c4_addr", {23'd0, ram_re, ram_addr}, 32'h105);
        step();
        chk("p1_c5_wreq", {31'd0, cpu_waitrequest}, 32'd0);
        sb_pop("p1_cpu_rdata", cpu_readdata);
        step();
        cpu_read = 1'b0;

        // Solo JTAG write so that JTAG holds the round-robin pointer
        jtag_cmd(1'b1, 8'h20, 32'hA5A5A5A5);
        step();
        chk("jwr_c1_we", {31'd0, ram_we}, 32'd1);
        chk("jwr_c1_wdata", ram_wdata, 32'hA5A5A5A5);
        step();
        chk("jwr_c2_ready", {30'd0, monitor_ready, monitor_error}, 32'd2);
        chk("jwr_mem", mem[8'h20], 32'hA5A5A5A5);

        // Second simultaneous pair: CPU first
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'hA5A5A5A5);
        cpu_read = 1'b1; cpu_address = 8'h10;
        jtag_cmd(1'b0, 8'h20, 32'h0);
        step();
        chk("p2_c1_addr", {23'd0, ram_re, ram_addr}, 32'h110);
        step();
        chk("p2_c2_wreq", {31'd0, cpu_waitrequest}, 32'd0);
        sb_pop("p2_cpu_rdata", cpu_readdata);
        step();
        cpu_read = 1'b0;
        chk("p2_c3_re", {31'd0, ram_re}, 32'd0);
        step();
        chk("p2_c4_addr", {23'd0, ram_re, ram_addr}, 32'h120);
        step(); step();
        chk("p2_c6_ready", {31'd0, monitor_ready}, 32'd1);
        sb_pop("p2_mondreg", MonDReg);

        // JTAG write while CPU not halted: suppressed, error, still completes
        debugack = 1'b0;
        jtag_cmd(1'b1, 8'h10, 32'h11111111);
        step();
        chk("nack_c1_we", {31'd0, ram_we}, 32'd0);
        step();
        chk("nack_status", {30'd0, monitor_ready, monitor_error}, 32'd3);
        chk("nack_mem", mem[8'h10], 32'hDEADBEEF);
        debugack = 1'b1;
        exp_q.push_back(32'hDEADBEEF);
        jtag_cmd(1'b0, 8'h10, 32'h0);
        chk("nack_clear", {30'd0, monitor_ready, monitor_error}, 32'd0);
        wait_ready();
        sb_pop("nack_mondreg", MonDReg);

        // Overflow: second strobe while the first is pending is dropped
        exp_q.push_back(32'hA5A5A5A5);
        jtag_req = 1'b1; jtag_wr = 1'b0; jtag_addr = 8'h20;
        step();
        jtag_addr = 8'h30;
        step();
        jtag_req = 1'b0;
        chk("ovf_c1_addr", {23'd0, ram_re, ram_addr}, 32'h120);
        chk("ovf_c1_error", {31'd0, monitor_error}, 32'd1);
        step(); step();
        chk("ovf_status", {30'd0, monitor_ready, monitor_error}, 32'd3);
        sb_pop("ovf_mondreg", MonDReg);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ovf_no_second", {31'd0, ram_re}, 32'd0);
        end

        // Reset during CAPTURE of a JTAG read
        jtag_cmd(1'b0, 8'h10, 32'h0);
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rmid_mondreg", MonDReg, 32'd0);
        chk("rmid_status", {28'd0, monitor_ready, monitor_error, ram_we, ram_re}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rmid_idle", {30'd0, monitor_ready, ram_re}, 32'd0);
        end

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
